user_event_arbiter: RTL and testbench

Merges game-control events from several input sources (keyboard decoder, push-button debouncer, gamepad) into one buffered stream for `main_game_logic`. Drives that module's `user_event_i` / `user_event_ready_i` and consumes its `user_event_rd_req_o`. Sources are served round-robin into a small FIFO. `EV_NEW_GAME` has absolute priority and flushes all pending moves.

---
 rtl/user_event_arbiter_pkg.sv | 24 ++
 rtl/user_event_arbiter_event_fifo.sv | 85 ++++++++
 rtl/user_event_arbiter.sv | 104 ++++++++++
 tb/tb_user_event_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/user_event_arbiter_pkg.sv
// Shared definitions for the user event arbiter.
// Holds the game-control event encoding, the legal-code mask and a small
// helper that classifies a 3-bit code as legal or not.
package user_event_arbiter_pkg;

  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_LEFT     = 3'd1,
    EV_RIGHT    = 3'd2,
    EV_DOWN     = 3'd3,
    EV_ROTATE   = 3'd4,
    EV_DROP     = 3'd5,
    EV_NEW_GAME = 3'd6,
    EV_RSVD     = 3'd7
  } ev_t;

  // Bit c set means code c is a legal event; EV_NONE and EV_RSVD are not.
  localparam logic [7:0] EV_VALID_MASK = 8'b0111_1110;

  function automatic logic ev_is_valid(input logic [2:0] code);
    return EV_VALID_MASK[code];
  endfunction

endpackage

// File: rtl/user_event_arbiter_event_fifo.sv
// event_fifo: small event queue with a storage-driven head.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   push_i       - write data_i at the tail (ignored when full without pop)
//   pop_i        - remove the head (ignored when empty)
//   flush_i      - discard everything and load data_i as the only entry
//   data_i       - 3-bit event code
//   head_o       - event at the head, 0 when empty
//   ready_o      - queue non-empty
//   full_o       - queue holds DEPTH entries
//   level_o      - current occupancy
module event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [2:0]                 data_i,
  output logic [2:0]                 head_o,
  output logic                       ready_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [2:0]    mem_q [DEPTH];
  logic [2:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign ready_o = (level_q != '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign head_o  = ready_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    do_pop   = pop_i && ready_o;
    do_push  = push_i && (!full_o || do_pop);
    if (flush_i) begin
      // Flush wins over push and pop: the queue restarts with one entry.
      mem_d[0] = data_i;
      rd_ptr_d = '0;
      wr_ptr_d = AW'(1);
      level_d  = LW'(1);
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop && !full_o) begin
        level_d = level_q + LW'(1);
      end else if (do_pop && !do_push) begin
        level_d = level_q - LW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/user_event_arbiter.sv
// user_event_arbiter: merges events from SRC_CNT sources into one buffered
// stream. NEW_GAME from any source wins outright and flushes the queue;
// other events are served round-robin while the queue has room.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   src_valid_i          - per-source event offer
//   src_event_i          - per-source code, source s in bits [3s+2:3s]
//   src_ack_o            - one-hot, offered event of source s taken this cycle
//   user_event_o         - event at the queue head
//   user_event_ready_o   - queue non-empty
//   user_event_rd_req_i  - consumer pops the head
//   fifo_level_o         - queue occupancy
//   drop_pulse_o         - one-cycle pulse, the cycle after an illegal code was acked
module user_event_arbiter
  import user_event_arbiter_pkg::*;
#(
  parameter int SRC_CNT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SRC_CNT-1:0]            src_valid_i,
  input  logic [3*SRC_CNT-1:0]          src_event_i,
  output logic [SRC_CNT-1:0]            src_ack_o,
  output logic [2:0]                    user_event_o,
  output logic                          user_event_ready_o,
  input  logic                          user_event_rd_req_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          drop_pulse_o
);

  localparam int PW = $clog2(SRC_CNT);

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] grant_idx;
  logic [2:0]    grant_code;
  logic          ng_hit, rr_hit, grant, flush, push, pop, fifo_full;
  logic          drop_pulse_q, drop_pulse_d;

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] p, input int unsigned step);
    return PW'((32'(p) + step) % SRC_CNT);
  endfunction

  assign pop = user_event_rd_req_i && user_event_ready_o;

  always_comb begin
    ng_hit    = 1'b0;
    rr_hit    = 1'b0;
    grant_idx = rr_ptr_q;
    for (int unsigned s = 0; s < SRC_CNT; s++) begin
      if (!ng_hit && src_valid_i[PW'(s)] && (src_event_i[3*s +: 3] == EV_NEW_GAME)) begin
        ng_hit    = 1'b1;
        grant_idx = PW'(s);
      end
    end
    if (!ng_hit) begin
      // Search starts one past the last served source.
      for (int unsigned i = 1; i <= SRC_CNT; i++) begin
        if (!rr_hit && src_valid_i[rr_next(rr_ptr_q, i)]) begin
          rr_hit    = 1'b1;
          grant_idx = rr_next(rr_ptr_q, i);
        end
      end
    end
    grant_code   = src_event_i[3*grant_idx +: 3];
    flush        = !rst && ng_hit;
    grant        = !rst && (ng_hit || (rr_hit && (!fifo_full || pop)));
    src_ack_o    = '0;
    if (grant) begin
      src_ack_o[grant_idx] = 1'b1;
    end
    push         = grant && !ng_hit && ev_is_valid(grant_code);
    drop_pulse_d = grant && !ng_hit && !ev_is_valid(grant_code);
    rr_ptr_d     = (grant && !ng_hit) ? grant_idx : rr_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= PW'(SRC_CNT - 1);
      drop_pulse_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  assign drop_pulse_o = drop_pulse_q;

  event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (user_event_rd_req_i),
    .flush_i (flush),
    .data_i  (grant_code),
    .head_o  (user_event_o),
    .ready_o (user_event_ready_o),
    .full_o  (fifo_full),
    .level_o (fifo_level_o)
  );

endmodule

// File: tb/tb_user_event_arbiter.sv
module tb_user_event_arbiter;

  localparam int N     = 2;
  localparam int DEPTH = 4;

  localparam int L   = 1;
  localparam int R   = 2;
  localparam int D   = 3;
  localparam int ROT = 4;
  localparam int DRP = 5;
  localparam int NG  = 6;
  localparam int BAD = 7;

  logic           clk;
  logic           rst;
  logic [N-1:0]   src_valid_i;
  logic [3*N-1:0] src_event_i;
  logic [N-1:0]   src_ack_o;
  logic [2:0]     user_event_o;
  logic           user_event_ready_o;
  logic           user_event_rd_req_i;
  logic [2:0]     fifo_level_o;
  logic           drop_pulse_o;

  int checks = 0;
  int errors = 0;

  user_event_arbiter #(
    .SRC_CNT(N),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .src_valid_i         (src_valid_i),
    .src_event_i         (src_event_i),
    .src_ack_o           (src_ack_o),
    .user_event_o        (user_event_o),
    .user_event_ready_o  (user_event_ready_o),
    .user_event_rd_req_i (user_event_rd_req_i),
    .fifo_level_o        (fifo_level_o),
    .drop_pulse_o        (drop_pulse_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of codes, last-served source, pending drop flag.
  int mq[$];
  int mrr;
  bit mdrop;
  int ng, g, code;
  bit mpop;
  int ea;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      mrr   = N - 1;
      mdrop = 1'b0;
      chk("rst_ack", int'(src_ack_o), 0);
      chk("rst_ready", int'(user_event_ready_o), 0);
      chk("rst_level", int'(fifo_level_o), 0);
      chk("rst_head", int'(user_event_o), 0);
      chk("rst_drop", int'(drop_pulse_o), 0);
    end else begin
      ng = -1;
      g  = -1;
      for (int s = 0; s < N; s++)
        if (ng < 0 && src_valid_i[s] && int'(src_event_i[3*s +: 3]) == NG) ng = s;
      mpop = user_event_rd_req_i && (mq.size() > 0);
      if (ng >= 0) g = ng;
      else if (mq.size() < DEPTH || mpop)
        for (int i = 1; i <= N; i++)
          if (g < 0 && src_valid_i[(mrr + i) % N]) g = (mrr + i) % N;
      ea = (g >= 0) ? (1 << g) : 0;
      chk("ack", int'(src_ack_o), ea);
      chk("ready", int'(user_event_ready_o), (mq.size() > 0) ? 1 : 0);
      chk("level", int'(fifo_level_o), mq.size());
      if (mq.size() > 0) chk("head", int'(user_event_o), mq[0]);
      chk("drop", int'(drop_pulse_o), int'(mdrop));
      mdrop = 1'b0;
      if (ng >= 0) begin
        mq.delete();
        mq.push_back(NG);
      end else begin
        if (mpop) void'(mq.pop_front());
        if (g >= 0) begin
          mrr  = g;
          code = int'(src_event_i[3*g +: 3]);
          if (code >= 1 && code <= 6) mq.push_back(code);
          else mdrop = 1'b1;
        end
      end
    end
  end

  task automatic drive(input logic [N-1:0] v, input int e0, input int e1, input logic rd);
    @(posedge clk);
    #1;
    src_valid_i         = v;
    src_event_i         = {3'(e1), 3'(e0)};
    user_event_rd_req_i = rd;
    #1;
  endtask

  initial begin
    rst                 = 1'b1;
    src_valid_i         = '0;
    src_event_i         = '0;
    user_event_rd_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single source, single event
    drive(2'b01, L, 0, 0);
    chk("t1_ack", int'(src_ack_o), 1);
    drive(2'b00, 0, 0, 0);
    chk("t1_ready", int'(user_event_ready_o), 1);
    chk("t1_head", int'(user_event_o), L);
    drive(2'b00, 0, 0, 1);
    drive(2'b00, 0, 0, 0);
    chk("t1_level", int'(fifo_level_o), 0);

    // Round-robin fairness from a fresh reset
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(2'b11, L, R, 1);
      chk("t2_ack", int'(src_ack_o), (k % 2 == 0) ? 1 : 2);
      if (k > 0) begin
        chk("t2_level", int'(fifo_level_o), 1);
        chk("t2_head", int'(user_event_o), (k % 2 == 1) ? L : R);
      end
    end
    drive(2'b00, 0, 0, 1);

    // Full back-pressure
    drive(2'b01, L, 0, 0);
    drive(2'b01, R, 0, 0);
    drive(2'b01, D, 0, 0);
    drive(2'b01, ROT, 0, 0);
    chk("t3_ack_last", int'(src_ack_o), 1);
    drive(2'b01, DRP, 0, 0);
    chk("t3_full_ack", int'(src_ack_o), 0);
    chk("t3_full_level", int'(fifo_level_o), 4);
    drive(2'b01, DRP, 0, 0);
    chk("t3_hold_ack", int'(src_ack_o), 0);
    drive(2'b01, DRP, 0, 1);
    chk("t3_pop_ack", int'(src_ack_o), 1);
    drive(2'b00, 0, 0, 0);
    chk("t3_pop_level", int'(fifo_level_o), 4);
    chk("t3_pop_head", int'(user_event_o), R);

    // NEW_GAME flush with 3 entries queued
    drive(2'b00, 0, 0, 1);
    drive(2'b11, D, NG, 1);
    chk("t4_ack", int'(src_ack_o), 2);
    chk("t4_level_before", int'(fifo_level_o), 3);
    drive(2'b00, 0, 0, 0);
    chk("t4_level", int'(fifo_level_o), 1);
    chk("t4_head", int'(user_event_o), NG);
    drive(2'b11, L, R, 0);
    chk("t4_rr_kept", int'(src_ack_o), 2);

    // Illegal code
    drive(2'b01, BAD, 0, 0);
    chk("t5_ack", int'(src_ack_o), 1);
    drive(2'b00, 0, 0, 0);
    chk("t5_drop", int'(drop_pulse_o), 1);
    chk("t5_level", int'(fifo_level_o), 2);
    drive(2'b00, 0, 0, 0);
    chk("t5_drop_end", int'(drop_pulse_o), 0);

    // Reset mid-operation with a source held valid
    drive(2'b01, L, 0, 0);
    @(posedge clk);
    #1;
    chk("t6_level_before", int'(fifo_level_o), 3);
    rst         = 1'b1;
    src_valid_i = 2'b01;
    src_event_i = {3'd0, 3'(L)};
    #1;
    chk("t6_rst_ready", int'(user_event_ready_o), 0);
    chk("t6_rst_level", int'(fifo_level_o), 0);
    chk("t6_rst_ack", int'(src_ack_o), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t6_release_ack", int'(src_ack_o), 1);
    drive(2'b00, 0, 0, 0);
    chk("t6_level", int'(fifo_level_o), 1);
    chk("t6_head", int'(user_event_o), L);
    drive(2'b00, 0, 0, 1);
    drive(2'b00, 0, 0, 0);
    drive(2'b00, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
